divider8bit_seq: RTL and testbench
==================================

Name: divider8bit_seq

Overview:
- Iterative restoring divider. It is the inverse of the ALU's combinational multiplier.
- Takes two's-complement 8-bit dividend/divisor and produces quotient and remainder over multiple cycles, using a start/busy/done handshake.
- Sits beside the ALU as a multi-cycle functional unit; the controller issues a divide opcode, then waits on done.
- Truncates toward zero; remainder takes the sign of the dividend.

Parameters:
WIDTH, 8, operand/result width; iteration count equals WIDTH
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned operands

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when busy=0
a  input  WIDTH  dividend, captured on accepted start
b  input  WIDTH  divisor, captured on accepted start
busy  output  1  high from the cycle after accept until done cycle inclusive
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_zero  output  1  divisor was zero
OF  output  1  signed overflow (most-negative / -1)
zero  output  1  quotient == 0 and div_zero == 0

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-high (rst).
- On rst, every output is 0 and the state is IDLE. rst mid-operation aborts immediately: no done pulse, and results clear to 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 (edge E0):
  - Capture sign_q = a[msb]^b[msb] and sign_r = a[msb] (both 0 when SIGNED=0).
  - Capture |a| and |b| (two's-complement negate when the sign bit is set and SIGNED=1).
  - Clear partial remainder; set count=0; busy goes high.
  - If b==0: go to DONE directly with quotient=all-ones, remainder=a, div_zero=1.
  - Otherwise go to CALC.
- CALC, one restoring step per edge:
  - Shift {rem,quo} left 1, with the dividend magnitude MSB entering.
  - Trial = rem - |b|. If it is non-negative, rem=trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - count increments. After WIDTH steps (edges E1..E8) go to FIX.
- FIX (E9):
  - quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem.
  - OF=1 iff SIGNED=1, a=most-negative and b=all-ones; the quotient is then the wrapped value 0x80.
  - zero is updated. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE with busy=0.
- Latency:
  - Normal divide: done is visible in the cycle after E9, i.e. 10 cycles of busy.
  - Divide-by-zero: done in the cycle after E0.
- Handshake and output holding:
  - start while busy=1 is ignored; no queueing.
  - start in the DONE cycle is ignored.
  - start in IDLE and the same cycle as done never coincide.
  - quotient, remainder, div_zero, OF and zero hold until the next accepted start.
  - Flags clear on accept; quotient and remainder hold until FIX or DONE rewrites them.
- Arithmetic widths:
  - Partial remainder and trial subtraction are WIDTH+1 bits.
  - Magnitude of the most-negative value is WIDTH bits unsigned, so 0x80 is treated as 128.
  - All negations are modulo 2^WIDTH.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3
  - count width $clog2(WIDTH+1)
  - MOST_NEG constant
  - ALU opcode value for divide (4'd12), which the ALU decoder will reuse
- Sub-module div_step (combinational):
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next remainder and quotient bit.
  - Kept separate so it can be unit-tested and reused if the divider is later unrolled.
- FSM, counter and sign fix-up live in the top module.

Test Plan:
- a=100 (0x64), b=7, start one cycle -> done pulse 10 cycles after the start edge; quotient=0x0E, remainder=0x02, div_zero=0, OF=0, zero=0.
- a=-100 (0x9C), b=7 -> quotient=0xF2 (-14), remainder=0xFE (-2). Also a=3, b=-7 -> quotient=0x00, remainder=0x03, zero=1.
- a=0x07, b=0 -> done in the cycle after start; quotient=0xFF, remainder=0x07, div_zero=1, zero=0, busy high exactly one cycle.
- a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, OF=1. Separately, SIGNED=0 build with a=200, b=3 -> quotient=66 (0x42), remainder=2, OF=0.
- Start 100/7, then pulse start with a=50, b=5 at cycle 3 -> second request ignored, result is still 14 r 2, exactly one done pulse.
- Start 100/7, assert rst at cycle 4 -> next cycle all outputs 0, busy=0, no done. Then start 9/2 -> quotient=4, remainder=1 after the normal latency.

Source files
------------

// File: rtl/divider8bit_seq_pkg.sv
// Shared definitions for the sequential divider: state encoding, widths,
// the most-negative operand constant and the ALU opcode that selects divide.
package divider8bit_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DIV_WIDTH = 8;
   localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

   localparam logic [DIV_WIDTH-1:0] MOST_NEG = 8'h80;

   // Opcode the ALU decoder uses to hand an operation to this unit.
   localparam logic [3:0] OP_DIV = 4'd12;

endpackage

// File: rtl/divider8bit_seq_if.sv
// Request/response bundle between the controller (master) and the divider (slave).
interface divider8bit_seq_if import divider8bit_seq_pkg::*; #(parameter int WIDTH = DIV_WIDTH) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;
   logic             OF;
   logic             zero;

   modport master (
      output start, a, b,
      input  busy, done, quotient, remainder, div_zero, OF, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, quotient, remainder, div_zero, OF, zero
   );

endinterface

// File: rtl/divider8bit_seq_div_step.sv
// One restoring-division step: shift the partial remainder left with the next
// dividend bit, try to subtract the divisor, keep the difference if it is not
// negative. The shifted value and trial difference carry one extra bit so a
// divisor magnitude of 2^(WIDTH-1) (most-negative operand) still fits.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             in_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Trial subtraction and restore decision.
   always_comb begin
      shifted = {rem_in, in_bit};
      trial   = shifted - {1'b0, divisor};
      if (trial[WIDTH] == 1'b0) begin
         rem_out = trial[WIDTH-1:0];
         q_bit   = 1'b1;
      end else begin
         rem_out = shifted[WIDTH-1:0];
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/divider8bit_seq.sv
// Iterative restoring divider with start/busy/done handshake. Works on operand
// magnitudes for WIDTH steps, then applies signs: quotient truncates toward
// zero, remainder follows the dividend sign. Divide-by-zero short-circuits.
module divider8bit_seq import divider8bit_seq_pkg::*; #(
   parameter int WIDTH  = DIV_WIDTH,
   parameter int SIGNED = 1
) (
   input  logic             clk,
   input  logic             rst,
   divider8bit_seq_if.slave bus
);

   localparam int             CW        = $clog2(WIDTH + 1);
   localparam logic           IS_SIGNED = (SIGNED != 0);
   localparam logic [WIDTH-1:0] MNEG    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZRO = {WIDTH{1'b0}};

   state_t           state;
   logic             sign_q;
   logic             sign_r;
   logic             ovf;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] quo;    // dividend magnitude shifts out the top, quotient bits enter the bottom
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      if (IS_SIGNED && v[WIDTH-1]) begin
         magnitude = ALL_ZRO - v;
      end else begin
         magnitude = v;
      end
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .in_bit  (quo[WIDTH-1]),
      .divisor (mag_b),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Sign fix-up of the finished magnitudes.
   always_comb begin
      quo_fix = quo;
      rem_fix = rem;
      if (sign_q) begin
         quo_fix = ALL_ZRO - quo;
      end else begin
         quo_fix = quo;
      end
      if (sign_r) begin
         rem_fix = ALL_ZRO - rem;
      end else begin
         rem_fix = rem;
      end
   end

   // Control FSM, iteration counter and registered result/flag outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sign_q        <= 1'b0;
         sign_r        <= 1'b0;
         ovf           <= 1'b0;
         mag_b         <= ALL_ZRO;
         quo           <= ALL_ZRO;
         rem           <= ALL_ZRO;
         count         <= {CW{1'b0}};
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.quotient  <= ALL_ZRO;
         bus.remainder <= ALL_ZRO;
         bus.div_zero  <= 1'b0;
         bus.OF        <= 1'b0;
         bus.zero      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sign_q       <= IS_SIGNED & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  sign_r       <= IS_SIGNED & bus.a[WIDTH-1];
                  ovf          <= IS_SIGNED & (bus.a == MNEG) & (bus.b == ALL_ONE);
                  quo          <= magnitude(bus.a);
                  mag_b        <= magnitude(bus.b);
                  rem          <= ALL_ZRO;
                  count        <= {CW{1'b0}};
                  bus.busy     <= 1'b1;
                  bus.OF       <= 1'b0;
                  bus.zero     <= 1'b0;
                  if (bus.b == ALL_ZRO) begin
                     bus.quotient  <= ALL_ONE;
                     bus.remainder <= bus.a;
                     bus.div_zero  <= 1'b1;
                     bus.done      <= 1'b1;
                     state         <= DONE;
                  end else begin
                     bus.div_zero  <= 1'b0;
                     state         <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               rem   <= step_rem;
               quo   <= {quo[WIDTH-2:0], step_q};
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end else begin
                  state <= CALC;
               end
            end
            FIX: begin
               bus.quotient  <= quo_fix;
               bus.remainder <= rem_fix;
               bus.OF        <= ovf;
               bus.zero      <= (quo_fix == ALL_ZRO);
               bus.done      <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider8bit_seq.sv
// Scoreboard bench for the sequential divider: a signed and an unsigned
// instance; expected results come from an integer reference model.
module tb_divider8bit_seq;
   import divider8bit_seq_pkg::*;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       of;
      logic       z;
      int         done_cyc;
      int         busy_len;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   busy_cnt_s = 0;
   int   busy_cnt_u = 0;
   exp_t sb_s[$];
   exp_t sb_u[$];
   exp_t es;
   exp_t eu;

   divider8bit_seq_if #(.WIDTH(8)) if_s ();
   divider8bit_seq_if #(.WIDTH(8)) if_u ();

   divider8bit_seq #(.WIDTH(8), .SIGNED(1)) u_dut_s (.clk(clk), .rst(rst), .bus(if_s));
   divider8bit_seq #(.WIDTH(8), .SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(if_u));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input bit sgn);
      exp_t e;
      int sa, sb, q, r;
      e = '{q: 8'h00, r: 8'h00, dz: 1'b0, of: 1'b0, z: 1'b0, done_cyc: 0, busy_len: 0};
      if (b == 8'h00) begin
         e.q  = 8'hFF;
         e.r  = a;
         e.dz = 1'b1;
      end else begin
         sa   = sgn ? int'($signed(a)) : int'(a);
         sb   = sgn ? int'($signed(b)) : int'(b);
         q    = sa / sb;
         r    = sa % sb;
         e.q  = q[7:0];
         e.r  = r[7:0];
         e.of = sgn && (a == MOST_NEG) && (b == 8'hFF);
      end
      e.z = (e.q == 8'h00) && !e.dz;
      return e;
   endfunction

   task automatic do_div(input bit uns, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      @(negedge clk);
      e = model(a, b, !uns);
      e.done_cyc = cyc + 1 + ((b == 8'h00) ? 0 : 9);
      e.busy_len = (b == 8'h00) ? 1 : 10;
      if (uns) begin
         if_u.a = a; if_u.b = b; if_u.start = 1'b1;
         sb_u.push_back(e);
      end else begin
         if_s.a = a; if_s.b = b; if_s.start = 1'b1;
         sb_s.push_back(e);
      end
      @(negedge clk);
      if_s.start = 1'b0;
      if_u.start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (sb_s.size() != 0 || sb_u.size() != 0); i++) @(negedge clk);
      check("drain", sb_s.size() + sb_u.size(), 0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, if_s.busy, 1'b0);
      check({tag, "_done"}, if_s.done, 1'b0);
      check({tag, "_quo"}, if_s.quotient, 8'h00);
      check({tag, "_rem"}, if_s.remainder, 8'h00);
      check({tag, "_dz"}, if_s.div_zero, 1'b0);
      check({tag, "_of"}, if_s.OF, 1'b0);
      check({tag, "_zero"}, if_s.zero, 1'b0);
      check({tag, "_u_quo"}, if_u.quotient, 8'h00);
   endtask

   // Signed-instance scoreboard: compare on every done pulse.
   always @(negedge clk) begin
      if (rst) busy_cnt_s = 0;
      else if (if_s.busy) busy_cnt_s++;
      if (if_s.done) begin
         if (sb_s.size() == 0) begin
            check("s_spurious_done", 32'd1, 32'd0);
         end else begin
            es = sb_s.pop_front();
            check("s_quo", if_s.quotient, es.q);
            check("s_rem", if_s.remainder, es.r);
            check("s_dz", if_s.div_zero, es.dz);
            check("s_of", if_s.OF, es.of);
            check("s_zero", if_s.zero, es.z);
            check("s_latency", cyc, es.done_cyc);
            check("s_busy_len", busy_cnt_s, es.busy_len);
            busy_cnt_s = 0;
         end
      end
   end

   // Unsigned-instance scoreboard.
   always @(negedge clk) begin
      if (rst) busy_cnt_u = 0;
      else if (if_u.busy) busy_cnt_u++;
      if (if_u.done) begin
         if (sb_u.size() == 0) begin
            check("u_spurious_done", 32'd1, 32'd0);
         end else begin
            eu = sb_u.pop_front();
            check("u_quo", if_u.quotient, eu.q);
            check("u_rem", if_u.remainder, eu.r);
            check("u_dz", if_u.div_zero, eu.dz);
            check("u_of", if_u.OF, eu.of);
            check("u_zero", if_u.zero, eu.z);
            check("u_latency", cyc, eu.done_cyc);
            check("u_busy_len", busy_cnt_u, eu.busy_len);
            busy_cnt_u = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      rst = 1'b1;
      if_s.start = 1'b0; if_s.a = 8'h00; if_s.b = 8'h00;
      if_u.start = 1'b0; if_u.a = 8'h00; if_u.b = 8'h00;
      $display("divide opcode %0d, count width %0d", OP_DIV, CNT_W);
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      // Directed signed cases.
      do_div(1'b0, 8'd100, 8'd7);    drain();
      do_div(1'b0, 8'h9C, 8'd7);     drain();
      do_div(1'b0, 8'd3, 8'hF9);     drain();
      do_div(1'b0, 8'h07, 8'h00);    drain();
      do_div(1'b0, 8'h80, 8'hFF);    drain();
      do_div(1'b0, 8'h80, 8'h01);    drain();
      do_div(1'b0, 8'h7F, 8'h80);    drain();

      // Directed unsigned cases.
      do_div(1'b1, 8'd200, 8'd3);    drain();
      do_div(1'b1, 8'h80, 8'hFF);    drain();
      do_div(1'b1, 8'hFF, 8'h00);    drain();

      // Start while busy must be ignored.
      do_div(1'b0, 8'd100, 8'd7);
      @(negedge clk);
      if_s.a = 8'd50; if_s.b = 8'd5; if_s.start = 1'b1;
      @(negedge clk);
      if_s.start = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      // Reset mid-operation aborts with no done pulse.
      if_s.a = 8'd100; if_s.b = 8'd7; if_s.start = 1'b1;
      @(negedge clk);
      if_s.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_cleared("abort");
      rst = 1'b0;
      repeat (12) @(negedge clk);
      do_div(1'b0, 8'd9, 8'd2);      drain();

      // Random operands on both instances.
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         do_div(1'b0, ra, rb);
         drain();
         do_div(1'b1, rb, ra);
         drain();
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
